alu_system: RTL and testbench
=============================

ALU_SYSTEM -- requirements
Module: alu_system

Interface
REQ-001 Clock  in  1  single system clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low; clears all registers.
REQ-003 RF_OutASel, RF_OutBSel  in  2 each  register-file read selects, 0..3 = R1..R4.
REQ-004 RF_FunSel  in  2  register-file op: 00 decrement, 01 increment, 10 load, 11 clear.
REQ-005 RF_RegSel  in  4  register-file enables, active-high: bit3 R1, bit2 R2, bit1 R3, bit0 R4.
REQ-006 ALU_FunSel  in  4  ALU operation select.
REQ-007 ARF_OutCSel, ARF_OutDSel  in  2 each  address-register-file read selects: 00 PC, 01 PC, 10 AR, 11 SP.
REQ-008 ARF_FunSel  in  2  same encoding as RF_FunSel.
REQ-009 ARF_RegSel  in  3  address-register-file enables, active-high: bit2 PC, bit1 AR, bit0 SP.
REQ-010 IR_LH, IR_Enable, IR_Funsel  in  1/1/2  instruction-register controls.
REQ-011 Mem_WR, Mem_CS  in  1/1  memory write enable (1 = write), chip select (active-low).
REQ-012 MuxASel, MuxBSel, MuxCSel  in  2/2/1  datapath mux selects.
REQ-013 AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut  out  8 each  datapath observation ports.
REQ-014 ALUOutFlag  out  4  registered flags {Z,C,N,O}, bit3 = Z, bit0 = O.
REQ-015 IROut  out  16  instruction register contents.

Function
REQ-016 The register file SHALL hold R1..R4 (8-bit); AOut/BOut are combinational reads.
REQ-017 On a rising edge, each enabled register SHALL load MuxAOut, increment or decrement by 1 (mod 256, wrap), or clear, per RF_FunSel; disabled registers hold.
REQ-018 The address register file SHALL hold PC, AR, SP (8-bit), loaded from MuxBOut with the same FunSel semantics; ARF_COut and Address are combinational reads via OutCSel and OutDSel.
REQ-019 The IR SHALL update only when IR_Enable=1: load writes MemoryOut to IR[7:0] if IR_LH=0 or to IR[15:8] if IR_LH=1, with the other byte held; inc/dec act on all 16 bits; clear zeroes all 16 bits.
REQ-020 MuxAOut SHALL be: 0 ALUOut, 1 MemoryOut, 2 IROut[7:0], 3 ARF_COut.
REQ-021 MuxBOut SHALL use the same mapping as MuxAOut.
REQ-022 MuxCOut SHALL be 0 AOut, 1 ARF_COut.
REQ-023 ALU operand A SHALL be MuxCOut and operand B SHALL be BOut.
REQ-024 ALU function codes SHALL be: 0 A; 1 B; 2 ~A; 3 ~B; 4 A+B; 5 A-B; 6 compare (output A, flags of A-B); 7 A&B; 8 A|B; 9 ~(A&B); A A^B; B LSL A; C LSR A; D ASL A; E ASR A; F rotate-right A through C.
REQ-025 Flags SHALL be latched into ALUOutFlag on every rising edge, with Z = (result==0) and N = result[7].
REQ-026 C SHALL be updated by add/sub/compare (carry-out; borrow as ~carry of A+~B+1) and by shifts/rotate (bit shifted out), and held by all other codes.
REQ-027 O SHALL be updated by add/sub/compare (signed overflow) and by ASL (sign change), and held by all other codes.
REQ-028 Memory SHALL be 256x8, addressed by Address; MemoryOut = mem[Address] combinationally when Mem_CS=0 and Mem_WR=0, else 8'h00.
REQ-029 When Mem_CS=0 and Mem_WR=1, the memory SHALL write ALUOut on the rising edge; memory SHALL initialise to all zeros.

Reset
REQ-030 While Reset=0, R1..R4, PC, AR, SP, IR and ALUOutFlag SHALL be 0 immediately, regardless of Clock; memory contents are not reset.
REQ-031 The first rising edge after Reset deasserts SHALL perform a normal update.

Verification
REQ-032 Reset low, then high; RF_RegSel=1000, FunSel=01 for one cycle -> R1=1, all other registers 0.
REQ-033 R1=5, R2=3; OutASel=0, OutBSel=1, MuxCSel=0, ALU_FunSel=4 -> ALUOut=8; next edge flags Z=0, C=0, N=0, O=0.
REQ-034 R1=8'h7F, R2=8'h01, ALU add -> ALUOut=8'h80, N=1, O=1, C=0; ALU_FunSel=5 with R1=R2=3 -> ALUOut=0, Z=1, C=1.
REQ-035 AR=8'h10 via MuxBSel=2; write ALUOut=8'hAB (Mem_CS=0, Mem_WR=1); then read (Mem_WR=0) -> MemoryOut=8'hAB; IR_Enable=1, LH=1, load -> IROut=16'hAB00.
REQ-036 PC=8'hFF, ARF_FunSel=01, RegSel=100 -> PC wraps to 0; R4=0 decrement -> R4=8'hFF.

Source files
------------

// File: rtl/alu_system_if.sv
// Control and observation bundle for the alu_system datapath.
interface alu_system_if;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [7:0]  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut;
    logic [3:0]  ALUOutFlag;
    logic [15:0] IROut;

    modport master (
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel,
        input  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut,
               ALUOutFlag, IROut
    );

    modport slave (
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel,
        output AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut, MuxAOut, MuxBOut, MuxCOut,
               ALUOutFlag, IROut
    );
endinterface

// File: rtl/alu_system.sv
// 8-bit datapath: register file, address registers, IR, ALU with latched {Z,C,N,O}, 256x8 RAM.
module alu_system (
    input  logic        Clock,
    input  logic        Reset,
    alu_system_if.slave bus
);
    localparam logic [1:0] FunDec  = 2'b00;
    localparam logic [1:0] FunInc  = 2'b01;
    localparam logic [1:0] FunLoad = 2'b10;

    logic [7:0]  rf_q  [4];
    logic [7:0]  rf_d  [4];
    logic [7:0]  arf_q [3];  // PC, AR, SP
    logic [7:0]  arf_d [3];
    logic [15:0] ir_q, ir_d;
    logic [3:0]  flag_q, flag_d;
    logic [7:0]  mem_q [256] = '{default: 8'h00};

    logic [7:0]  a_op, b_op, arf_c, addr, mem_out, alu_res, flag_res, mux_a, mux_b;
    logic [8:0]  sum;
    logic        c_new, o_new;

    function automatic logic [7:0] reg_next(input logic [1:0] fun, input logic [7:0] cur,
                                            input logic [7:0] ld);
        case (fun)
            FunDec:  reg_next = cur - 8'd1;
            FunInc:  reg_next = cur + 8'd1;
            FunLoad: reg_next = ld;
            default: reg_next = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] arf_pick(input logic [1:0] sel, input logic [7:0] pc,
                                            input logic [7:0] ar, input logic [7:0] sp);
        case (sel)
            2'b10:   arf_pick = ar;
            2'b11:   arf_pick = sp;
            default: arf_pick = pc;
        endcase
    endfunction

    function automatic logic [7:0] mux4(input logic [1:0] sel, input logic [7:0] s0,
                                        input logic [7:0] s1, input logic [7:0] s2,
                                        input logic [7:0] s3);
        case (sel)
            2'd0:    mux4 = s0;
            2'd1:    mux4 = s1;
            2'd2:    mux4 = s2;
            default: mux4 = s3;
        endcase
    endfunction

    always_comb begin
        arf_c   = arf_pick(bus.ARF_OutCSel, arf_q[0], arf_q[1], arf_q[2]);
        addr    = arf_pick(bus.ARF_OutDSel, arf_q[0], arf_q[1], arf_q[2]);
        mem_out = (!bus.Mem_CS && !bus.Mem_WR) ? mem_q[addr] : 8'h00;
        a_op    = bus.MuxCSel ? arf_c : rf_q[bus.RF_OutASel];
        b_op    = rf_q[bus.RF_OutBSel];
        mux_a   = mux4(bus.MuxASel, alu_res, mem_out, ir_q[7:0], arf_c);
        mux_b   = mux4(bus.MuxBSel, alu_res, mem_out, ir_q[7:0], arf_c);
    end

    // C and O keep their latched value unless the operation defines them.
    always_comb begin
        sum     = 9'd0;
        alu_res = a_op;
        c_new   = flag_q[1];
        o_new   = flag_q[0];
        unique case (bus.ALU_FunSel)
            4'h0: alu_res = a_op;
            4'h1: alu_res = b_op;
            4'h2: alu_res = ~a_op;
            4'h3: alu_res = ~b_op;
            4'h4: begin
                sum     = {1'b0, a_op} + {1'b0, b_op};
                alu_res = sum[7:0];
                c_new   = sum[8];
                o_new   = (a_op[7] == b_op[7]) && (sum[7] != a_op[7]);
            end
            4'h5, 4'h6: begin
                sum     = {1'b0, a_op} + {1'b0, ~b_op} + 9'd1;
                alu_res = sum[7:0];
                c_new   = sum[8];
                o_new   = (a_op[7] != b_op[7]) && (sum[7] != a_op[7]);
            end
            4'h7: alu_res = a_op & b_op;
            4'h8: alu_res = a_op | b_op;
            4'h9: alu_res = ~(a_op & b_op);
            4'hA: alu_res = a_op ^ b_op;
            4'hB: begin
                alu_res = {a_op[6:0], 1'b0};
                c_new   = a_op[7];
            end
            4'hC: begin
                alu_res = {1'b0, a_op[7:1]};
                c_new   = a_op[0];
            end
            4'hD: begin
                alu_res = {a_op[6:0], 1'b0};
                c_new   = a_op[7];
                o_new   = a_op[7] ^ a_op[6];
            end
            4'hE: begin
                alu_res = {a_op[7], a_op[7:1]};
                c_new   = a_op[0];
            end
            4'hF: begin
                alu_res = {flag_q[1], a_op[7:1]};
                c_new   = a_op[0];
            end
        endcase
        flag_res = alu_res;
        // Compare passes A through but flags reflect A-B.
        if (bus.ALU_FunSel == 4'h6) alu_res = a_op;
        flag_d = {flag_res == 8'h00, c_new, flag_res[7], o_new};
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rf_d[i] = rf_q[i];
            if (bus.RF_RegSel[3-i]) rf_d[i] = reg_next(bus.RF_FunSel, rf_q[i], mux_a);
        end
        for (int i = 0; i < 3; i++) begin
            arf_d[i] = arf_q[i];
            if (bus.ARF_RegSel[2-i]) arf_d[i] = reg_next(bus.ARF_FunSel, arf_q[i], mux_b);
        end
        ir_d = ir_q;
        if (bus.IR_Enable) begin
            case (bus.IR_Funsel)
                FunDec:  ir_d = ir_q - 16'd1;
                FunInc:  ir_d = ir_q + 16'd1;
                FunLoad: begin
                    if (bus.IR_LH) ir_d[15:8] = mem_out;
                    else           ir_d[7:0]  = mem_out;
                end
                default: ir_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
            for (int i = 0; i < 3; i++) arf_q[i] <= 8'h00;
            ir_q   <= 16'h0000;
            flag_q <= 4'h0;
        end else begin
            rf_q   <= rf_d;
            arf_q  <= arf_d;
            ir_q   <= ir_d;
            flag_q <= flag_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge Clock) begin
        if (!bus.Mem_CS && bus.Mem_WR) mem_q[addr] <= alu_res;
    end

    assign bus.AOut       = rf_q[bus.RF_OutASel];
    assign bus.BOut       = b_op;
    assign bus.ALUOut     = alu_res;
    assign bus.ARF_COut   = arf_c;
    assign bus.Address    = addr;
    assign bus.MemoryOut  = mem_out;
    assign bus.MuxAOut    = mux_a;
    assign bus.MuxBOut    = mux_b;
    assign bus.MuxCOut    = a_op;
    assign bus.ALUOutFlag = flag_q;
    assign bus.IROut      = ir_q;
endmodule

// File: tb/tb_alu_system.sv
// Directed bench for alu_system with an arithmetic reference model checked every cycle.
module tb_alu_system;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_system_if bus ();

    alu_system dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] a, b, c, addr, mem, ma, mb, mc, alu;
        logic [3:0] fl;
    } exp_t;

    logic [7:0]  m_rf  [4]   = '{default: 8'h00};
    logic [7:0]  m_arf [3]   = '{default: 8'h00};
    logic [7:0]  m_mem [256] = '{default: 8'h00};
    logic [15:0] m_ir   = 16'h0000;
    logic [3:0]  m_flag = 4'h0;
    exp_t        ex;

    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a8,
                                              input logic [7:0] b8, input logic [3:0] fl);
        int a  = int'(a8);
        int b  = int'(b8);
        int sa = int'($signed(a8));
        int sb = int'($signed(b8));
        int r  = 0;
        int fr;
        int sr;
        logic c = fl[1];
        logic o = fl[0];
        case (op)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: r = 255 - a;
            4'h3: r = 255 - b;
            4'h4: begin
                r = (a + b) % 256; c = (a + b) > 255;
                sr = sa + sb; o = (sr > 127) || (sr < -128);
            end
            4'h5, 4'h6: begin
                r = (a - b + 256) % 256; c = (a >= b);
                sr = sa - sb; o = (sr > 127) || (sr < -128);
            end
            4'h7: r = int'(a8 & b8);
            4'h8: r = int'(a8 | b8);
            4'h9: r = 255 - int'(a8 & b8);
            4'hA: r = int'(a8 ^ b8);
            4'hB: begin r = (a * 2) % 256; c = a > 127; end
            4'hC: begin r = a / 2; c = a8[0]; end
            4'hD: begin r = (a * 2) % 256; c = a > 127; o = (a > 127) != (r > 127); end
            4'hE: begin r = a / 2 + (a > 127 ? 128 : 0); c = a8[0]; end
            default: begin r = a / 2 + (fl[1] ? 128 : 0); c = a8[0]; end
        endcase
        fr = r;
        if (op == 4'h6) r = a;
        return {r[7:0], fr == 0, c, fr > 127, o};
    endfunction

    function automatic logic [7:0] arf_model(input logic [1:0] sel);
        case (sel)
            2'd2:    return m_arf[1];
            2'd3:    return m_arf[2];
            default: return m_arf[0];
        endcase
    endfunction

    function automatic logic [7:0] fun8(input logic [1:0] f, input logic [7:0] cur,
                                        input logic [7:0] ld);
        case (f)
            2'b00:   return 8'((int'(cur) + 255) % 256);
            2'b01:   return 8'((int'(cur) + 1) % 256);
            2'b10:   return ld;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] ir_model(input logic [1:0] f, input logic lh,
                                             input logic [7:0] memv);
        case (f)
            2'b00:   return 16'((int'(m_ir) + 65535) % 65536);
            2'b01:   return 16'((int'(m_ir) + 1) % 65536);
            2'b10:   return lh ? {memv, m_ir[7:0]} : {m_ir[15:8], memv};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic exp_t model_eval();
        exp_t        e;
        logic [7:0]  src [4];
        logic [11:0] r;
        e.a    = m_rf[bus.RF_OutASel];
        e.b    = m_rf[bus.RF_OutBSel];
        e.c    = arf_model(bus.ARF_OutCSel);
        e.addr = arf_model(bus.ARF_OutDSel);
        e.mem  = (bus.Mem_CS == 1'b0 && bus.Mem_WR == 1'b0) ? m_mem[e.addr] : 8'h00;
        e.mc   = bus.MuxCSel ? e.c : e.a;
        r      = alu_model(bus.ALU_FunSel, e.mc, e.b, m_flag);
        e.alu  = r[11:4];
        e.fl   = r[3:0];
        src[0] = e.alu;
        src[1] = e.mem;
        src[2] = m_ir[7:0];
        src[3] = e.c;
        e.ma   = src[bus.MuxASel];
        e.mb   = src[bus.MuxBSel];
        return e;
    endfunction

    always_comb ex = model_eval();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_rf[i] <= 8'h00;
            for (int i = 0; i < 3; i++) m_arf[i] <= 8'h00;
            m_ir   <= 16'h0000;
            m_flag <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.RF_RegSel[3-i]) m_rf[i] <= fun8(bus.RF_FunSel, m_rf[i], ex.ma);
            for (int i = 0; i < 3; i++)
                if (bus.ARF_RegSel[2-i]) m_arf[i] <= fun8(bus.ARF_FunSel, m_arf[i], ex.mb);
            if (bus.IR_Enable) m_ir <= ir_model(bus.IR_Funsel, bus.IR_LH, ex.mem);
            m_flag <= ex.fl;
            if (!bus.Mem_CS && bus.Mem_WR) m_mem[ex.addr] <= ex.alu;
        end
    end

    task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp8("AOut", bus.AOut, ex.a);
            cmp8("BOut", bus.BOut, ex.b);
            cmp8("ALUOut", bus.ALUOut, ex.alu);
            cmp8("ARF_COut", bus.ARF_COut, ex.c);
            cmp8("Address", bus.Address, ex.addr);
            cmp8("MemoryOut", bus.MemoryOut, ex.mem);
            cmp8("MuxAOut", bus.MuxAOut, ex.ma);
            cmp8("MuxBOut", bus.MuxBOut, ex.mb);
            cmp8("MuxCOut", bus.MuxCOut, ex.mc);
            cmp8("ALUOutFlag", {4'h0, bus.ALUOutFlag}, {4'h0, m_flag});
            cmp16("IROut", bus.IROut, m_ir);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.RF_RegSel  = 4'b0000;
        bus.ARF_RegSel = 3'b000;
        bus.IR_Enable  = 1'b0;
        bus.Mem_CS     = 1'b1;
        bus.Mem_WR     = 1'b0;
    endtask

    // Clear the register, then count up or down to the target value.
    task automatic rf_set(input int idx, input logic [7:0] v);
        idle();
        bus.RF_RegSel = 4'b1000 >> idx;
        bus.RF_FunSel = 2'b11;
        tick();
        bus.RF_FunSel = (v < 8'h80) ? 2'b01 : 2'b00;
        for (int n = 0; n < ((v < 8'h80) ? int'(v) : 256 - int'(v)); n++) tick();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.RF_OutASel = 2'd0; bus.RF_OutBSel = 2'd1; bus.RF_FunSel = 2'b00;
        bus.ALU_FunSel = 4'h0; bus.ARF_OutCSel = 2'd0; bus.ARF_OutDSel = 2'd0;
        bus.ARF_FunSel = 2'b00; bus.IR_LH = 1'b0; bus.IR_Funsel = 2'b00;
        bus.MuxASel = 2'd0; bus.MuxBSel = 2'd0; bus.MuxCSel = 1'b0;
        idle();
        tick();
        chk_en = 1'b1;
        tick();
        cmp8("rst_R1", bus.AOut, 8'h00);
        cmp8("rst_PC", bus.ARF_COut, 8'h00);
        cmp8("rst_flags", {4'h0, bus.ALUOutFlag}, 8'h00);
        cmp16("rst_IR", bus.IROut, 16'h0000);

        // First edge after release increments R1 only.
        rst_n = 1'b1;
        bus.RF_RegSel = 4'b1000; bus.RF_FunSel = 2'b01;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.RF_OutASel = 2'(i);
            #1 cmp8("first_inc", bus.AOut, (i == 0) ? 8'h01 : 8'h00);
        end

        // 5 + 3
        rf_set(0, 8'h05);
        rf_set(1, 8'h03);
        bus.RF_OutASel = 2'd0; bus.RF_OutBSel = 2'd1; bus.MuxCSel = 1'b0; bus.ALU_FunSel = 4'h4;
        #1 cmp8("add_5_3", bus.ALUOut, 8'h08);
        tick();
        cmp8("add_5_3_flags", {4'h0, bus.ALUOutFlag}, 8'b0000_0000);

        // 7F + 01 overflows to 80 (N=1, O=1)
        rf_set(0, 8'h7F);
        rf_set(1, 8'h01);
        #1 cmp8("add_ovf", bus.ALUOut, 8'h80);
        tick();
        cmp8("add_ovf_flags", {4'h0, bus.ALUOutFlag}, 8'b0000_0011);

        // 3 - 3 = 0 (Z=1, C=1 meaning no borrow)
        rf_set(0, 8'h03);
        rf_set(1, 8'h03);
        bus.ALU_FunSel = 4'h5;
        #1 cmp8("sub_zero", bus.ALUOut, 8'h00);
        tick();
        cmp8("sub_zero_flags", {4'h0, bus.ALUOutFlag}, 8'b0000_1100);
        bus.ALU_FunSel = 4'h6;
        #1 cmp8("cmp_passes_a", bus.ALUOut, 8'h03);
        tick();
        cmp8("cmp_flags", {4'h0, bus.ALUOutFlag}, 8'b0000_1100);

        // ASR of C5 -> E2, C=1, N=1, O held at 0
        bus.ALU_FunSel = 4'h0;
        rf_set(0, 8'hC5);
        rf_set(1, 8'h3A);
        bus.ALU_FunSel = 4'hE;
        #1 cmp8("asr_c5", bus.ALUOut, 8'hE2);
        tick();
        cmp8("asr_c5_flags", {4'h0, bus.ALUOutFlag}, 8'b0000_0110);
        for (int op = 0; op < 16; op++) begin
            bus.ALU_FunSel = 4'(op);
            tick();
        end

        // AR <- IR[7:0] = 0x10, then write/read RAM
        bus.ALU_FunSel = 4'h0;
        bus.IR_Enable = 1'b1; bus.IR_Funsel = 2'b01;
        repeat (16) tick();
        idle();
        bus.MuxBSel = 2'd2; bus.ARF_RegSel = 3'b010; bus.ARF_FunSel = 2'b10;
        tick();
        idle();
        bus.ARF_OutDSel = 2'd2;
        #1 cmp8("ar_load", bus.Address, 8'h10);
        bus.IR_Enable = 1'b1; bus.IR_Funsel = 2'b11;
        tick();
        idle();
        rf_set(0, 8'hAB);
        bus.RF_OutASel = 2'd0; bus.MuxCSel = 1'b0;
        bus.Mem_CS = 1'b0; bus.Mem_WR = 1'b1;
        #1 cmp8("mem_out_during_write", bus.MemoryOut, 8'h00);
        tick();
        bus.Mem_WR = 1'b0;
        #1 cmp8("mem_readback", bus.MemoryOut, 8'hAB);
        bus.IR_Enable = 1'b1; bus.IR_LH = 1'b1; bus.IR_Funsel = 2'b10;
        bus.MuxASel = 2'd1; bus.RF_RegSel = 4'b0010; bus.RF_FunSel = 2'b10;
        tick();
        idle();
        bus.RF_OutBSel = 2'd2;
        #1 cmp16("ir_load_high", bus.IROut, 16'hAB00);
        cmp8("r3_from_mem", bus.BOut, 8'hAB);
        cmp8("mem_deselected", bus.MemoryOut, 8'h00);

        // PC wraps 0 -> FF -> 0; R4 decrements 0 -> FF
        bus.ARF_RegSel = 3'b100; bus.ARF_FunSel = 2'b00;
        tick();
        idle();
        bus.ARF_OutCSel = 2'd1;
        #1 cmp8("pc_dec_wrap", bus.ARF_COut, 8'hFF);
        bus.ARF_RegSel = 3'b100; bus.ARF_FunSel = 2'b01;
        tick();
        idle();
        #1 cmp8("pc_inc_wrap", bus.ARF_COut, 8'h00);
        rf_set(3, 8'h00);
        bus.RF_RegSel = 4'b0001; bus.RF_FunSel = 2'b00;
        tick();
        idle();
        bus.RF_OutBSel = 2'd3;
        #1 cmp8("r4_dec_wrap", bus.BOut, 8'hFF);

        // ALU operand A from AR
        bus.MuxCSel = 1'b1; bus.ARF_OutCSel = 2'd2; bus.MuxASel = 2'd3;
        for (int op = 0; op < 16; op++) begin
            bus.ALU_FunSel = 4'(op);
            tick();
        end

        // Asynchronous reset between edges
        bus.MuxCSel = 1'b0; bus.ALU_FunSel = 4'h0;
        #2 rst_n = 1'b0;
        #1 cmp16("async_rst_IR", bus.IROut, 16'h0000);
        cmp8("async_rst_flags", {4'h0, bus.ALUOutFlag}, 8'h00);
        cmp8("async_rst_R4", bus.BOut, 8'h00);
        tick();
        rst_n = 1'b1;
        bus.RF_OutASel = 2'd0; bus.RF_RegSel = 4'b1000; bus.RF_FunSel = 2'b01;
        tick();
        idle();
        #1 cmp8("post_rst_inc", bus.AOut, 8'h01);
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
